// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_TRAP  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_flopre.sv
// N-bit register with synchronous reset to a parameterised value and load enable.
module flopre #(
    parameter int           N       = 64,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC select, imem req/ack and a held instruction for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap on a misaligned next PC (adds fetch_fault).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       PCBranch,
    input  logic [N-1:0]       BranchReg,
    input  logic               PCSrc,
    input  logic               BranchSrc,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [N-1:0]       pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               fetch_fault
`endif
);
    fetch_state_t state_q, state_d;
    logic [N-1:0] pc_d;
    logic         advance;
    logic         capture;

    assign advance = (state_q == S_VALID) && instr_ready;
    assign capture = (state_q == S_REQ) && imem_ack;

    // Branch controls are only meaningful at the advance edge; pc_en masks them otherwise.
    always_comb begin
        pc_d = pc + N'(PC_INC);
        if (PCSrc) pc_d = BranchSrc ? BranchReg : PCBranch;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (imem_ack) state_d = S_VALID;
            S_VALID: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = (pc_d[1:0] != 2'b00) ? S_TRAP : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP:  state_d = S_TRAP;
`endif
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    flopre #(.N(N), .RST_VAL(PC_RESET)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .d     (pc_d),
        .q     (pc)
    );

    flopre #(.N(INSTR_W), .RST_VAL('0)) u_instr (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .d     (imem_rdata),
        .q     (instr)
    );

    // Request is masked during the reset cycle so a pending fetch is abandoned immediately.
    assign imem_req    = (state_q == S_REQ) && !reset;
    assign imem_addr   = pc;
    assign instr_valid = (state_q == S_VALID);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == S_TRAP);
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized memory latency and branches.
module tb_fetch_unit;
    localparam int           N   = 64;
    localparam logic [N-1:0] PCR = '0;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] PCBranch, BranchReg;
    logic         PCSrc, BranchSrc;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         instr_valid, instr_ready;
    logic [31:0]  instr;
    logic [N-1:0] pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         fetch_fault;
`endif

    fetch_unit #(.N(N), .PC_RESET(PCR)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCBranch    (PCBranch),
        .BranchReg   (BranchReg),
        .PCSrc       (PCSrc),
        .BranchSrc   (BranchSrc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Transaction-level reference: either waiting for a fetch, holding an instruction, or trapped.
    logic [N-1:0] m_pc = '0;
    logic [31:0]  m_instr = '0;
    bit           m_hold = 1'b0;
    bit           m_trap = 1'b0;
    bit           m_live = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, check settled outputs, advance model past the rising edge.
    task automatic cyc(input bit rst, input bit ack, input bit rdy, input bit ps, input bit bs,
                       input logic [N-1:0] pb, input logic [N-1:0] br, input logic [31:0] rd);
        logic [N-1:0] nxt;
        reset = rst; imem_ack = ack; instr_ready = rdy; PCSrc = ps; BranchSrc = bs;
        PCBranch = pb; BranchReg = br; imem_rdata = rd;
        #1;
        if (m_live) begin
            chk("req", 64'(imem_req), 64'(!rst && !m_hold && !m_trap));
            if (!rst && !m_hold && !m_trap) chk("addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("valid", 64'(instr_valid), 64'(m_hold));
            chk("instr", 64'(instr), 64'(m_instr));
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("fault", 64'(fetch_fault), 64'(m_trap));
`endif
        end
        if (rst) begin
            m_pc = PCR; m_instr = '0; m_hold = 0; m_trap = 0; m_live = 1;
        end else if (m_trap) begin
            m_trap = 1;
        end else if (!m_hold) begin
            if (ack) begin m_instr = rd; m_hold = 1; end
        end else if (rdy) begin
            nxt = ps ? (bs ? br : pb) : m_pc + 64'd4;
            m_pc = nxt;
            m_hold = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (nxt[1:0] != 2'b00) m_trap = 1;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int lat;
        logic [N-1:0] pb, br;
        reset = 1; imem_ack = 0; instr_ready = 0; PCSrc = 0; BranchSrc = 0;
        PCBranch = '0; BranchReg = '0; imem_rdata = '0;
        @(negedge clk);
        cyc(1, 1, 0, 0, 0, '0, '0, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0, 0, '0, '0, 32'h0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);

        // Zero-wait memory, always ready, sequential flow.
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (!m_hold) begin
                chk($sformatf("zw_addr%0d", k), imem_addr, 64'(4 * k));
                k++;
            end
            cyc(0, !m_hold, 1, 0, 0, '0, '0, 32'h1000 + 32'(i));
        end

        // Three-cycle latency at 0x10.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, '0, '0, 32'h1234_5678);
        chk("dly_addr", imem_addr, 64'h10);
        cyc(0, 1, 1, 0, 0, '0, '0, 32'hDEAD_BEEF);
        chk("dly_instr", 64'(instr), 64'hDEAD_BEEF);

        // Branches: to 0x20, then PCBranch 0x100, then BranchReg 0x2000.
        cyc(0, 0, 1, 1, 0, 64'h20, 64'h0, 32'h0);
        cyc(0, 1, 1, 0, 0, '0, '0, 32'hA000_0020);
        cyc(0, 0, 1, 1, 0, 64'h100, 64'h2000, 32'h0);
        chk("br_pcbranch", imem_addr, 64'h100);
        cyc(0, 1, 1, 0, 0, '0, '0, 32'hA000_0100);
        cyc(0, 0, 1, 1, 1, 64'h100, 64'h2000, 32'h0);
        chk("br_branchreg", imem_addr, 64'h2000);

        // Stall five cycles in the valid phase with branch controls toggling and a stray ack.
        cyc(0, 1, 0, 0, 0, '0, '0, 32'h5555_AAAA);
        for (int i = 0; i < 5; i++) cyc(0, i == 2, 0, i[0], 1, 64'h40, 64'h80, 32'h0BAD_0BAD);
        chk("stall_instr", 64'(instr), 64'h5555_AAAA);
        chk("stall_pc", pc, 64'h2000);

        // Reset while a request is outstanding with a same-cycle ack.
        cyc(0, 0, 1, 0, 0, '0, '0, 32'h0);
        cyc(1, 1, 0, 0, 0, '0, '0, 32'hBAAD_F00D);
        chk("rstreq_pc", pc, PCR);
        chk("rstreq_instr", 64'(instr), 64'h0);
        cyc(0, 0, 0, 0, 0, '0, '0, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        cyc(0, 1, 0, 0, 0, '0, '0, 32'h7777_0000);
        cyc(0, 0, 1, 1, 0, 64'h102, 64'h0, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, '0, '0, 32'h0);
        chk("trap_fault", 64'(fetch_fault), 64'h1);
        chk("trap_pc", pc, 64'h102);
        cyc(1, 0, 0, 0, 0, '0, '0, 32'h0);
`endif

        // Randomized memory latency, readiness, branches and occasional resets.
        lat = 0;
        for (int i = 0; i < 800; i++) begin
            bit rst, ack;
            rst = ($urandom_range(0, 49) == 0);
            if (!m_hold && !m_trap) begin
                if (lat == 0) begin ack = 1; lat = $urandom_range(0, 3); end
                else begin ack = 0; lat--; end
            end else begin
                ack = ($urandom_range(0, 9) == 0);
            end
            pb = {$urandom, $urandom};
            br = {$urandom, $urandom};
            if ($urandom_range(0, 9) != 0) pb[1:0] = 2'b00;
            if ($urandom_range(0, 9) != 0) br[1:0] = 2'b00;
            if (i % 97 == 0) pb = '1 & ~64'h3;
            cyc(rst, ack, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, pb, br, $urandom);
        end

        // PC+4 wrap at the top of the address space.
        cyc(1, 0, 0, 0, 0, '0, '0, 32'h0);
        cyc(0, 1, 0, 0, 0, '0, '0, 32'h1111_1111);
        cyc(0, 0, 1, 1, 1, '0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
        cyc(0, 1, 0, 0, 0, '0, '0, 32'h2222_2222);
        cyc(0, 0, 1, 0, 0, '0, '0, 32'h0);
        chk("wrap_pc", pc, 64'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
